btb_update_ctrl: RTL and testbench
==================================

# btb_update_ctrl

Scheduler for all writes into the branch target buffer and its direction predictor. Accepts branch-resolution reports from the execute stage, buffers them in a small queue, and drains at most one per cycle onto the BTB write port. Also runs a full-table invalidate sweep on request (ASID change / `ibar`), which has priority over queued updates. Sits between ex0 and the BTB; the fetch-side read path is untouched.

## Interface
- `DEPTH`, 4, update queue entries (power of two, ≥2)
- `INDEX_WIDTH`, 8, BTB index width; index = `pc[INDEX_WIDTH+2:3]`

- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `upd_valid`  in  1  resolution report valid
- `upd_ready`  out  1  report can be accepted this cycle
- `upd_pc`  in  32  PC of resolved fetch group
- `upd_tpc`  in  32  actual target PC
- `upd_taken`  in  1  branch actually taken
- `upd_btype`  in  2  00 none, 01 uncond, 10 PC-relative cond, 11 indirect
- `upd_dir_fail`  in  1  direction mispredicted
- `upd_add_fail`  in  1  target mispredicted
- `inv_req`  in  1  one-cycle pulse: invalidate whole BTB
- `inv_busy`  out  1  sweep in progress
- `btb_we`  out  1  BTB entry write strobe
- `btb_widx`  out  INDEX_WIDTH  BTB entry index
- `btb_wtarget`  out  32  target written
- `btb_wvalid`  out  1  valid bit written (1 insert, 0 clear)
- `dir_we`  out  1  direction-counter training strobe
- `dir_taken`  out  1  training outcome

## Operation
- States: IDLE (queue empty), DRAIN (queue non-empty), SWEEP.
- Handshake: report accepted when `upd_valid && upd_ready`. `upd_ready = !full && state!=SWEEP`.
- Filter: accepted report enqueued only if `upd_add_fail || upd_dir_fail || upd_btype==2'b00`; otherwise accepted and dropped.
- Coalesce: if newest queued entry has same index and is not being dequeued this cycle, overwrite it instead of pushing.
- Dequeue (DRAIN): head popped every cycle; head drives outputs combinationally that cycle:
  - `upd_btype==00` -> `btb_we=1, btb_wvalid=0` (clear false entry).
  - `upd_taken && upd_add_fail` -> `btb_we=1, btb_wvalid=1, btb_wtarget=tpc`.
  - `upd_btype==10` -> `dir_we=1, dir_taken=upd_taken`.
  - Otherwise `btb_we=0`; `dir_we` per rule above.
- Simultaneous push and pop: allowed when not full; count unchanged.
- `inv_req` in any state: queue flushed (entries discarded, stale ASID), counter cleared to 0, next state SWEEP. Report presented in same cycle is dropped.
- SWEEP: each cycle `btb_we=1, btb_wvalid=0, btb_wtarget=0, btb_widx=counter`, counter+1; after index `2^INDEX_WIDTH-1` -> IDLE. `dir_we=0`. `inv_req` during SWEEP restarts counter at 0.
- Counter is INDEX_WIDTH+1 bits; terminal condition = low bits all ones, no wrap into a second pass.

## Timing
- Reset: queue empty, state IDLE, counter 0; `upd_ready=1`, `inv_busy=0`, `btb_we=0`, `dir_we=0`, `btb_widx=0`, `btb_wtarget=0`, `btb_wvalid=0`, `dir_taken=0`. `rst` with `inv_req` high: reset wins.
- Enqueue latency: report accepted cycle N -> write strobe earliest cycle N+1.
- Sweep: `inv_req` at N -> `inv_busy` and first clear at N+1; last clear (index 255) at N+256; `inv_busy=0`, `upd_ready=1` at N+257.
- Full: `upd_ready=0`; the coalescing path also blocked while full.
- Outputs valid only with their strobe; other values don't-care but held deterministic (zero when idle).

## Structure
- Shared package: btype encodings (`BT_NONE/UNCOND/PCREL/INDIRECT`), state encodings, queue-entry struct (idx, tpc, taken, btype, dir_fail, add_fail).
- One sub-module: `btb_upd_fifo` (DEPTH entries, push/pop/overwrite-tail/flush, count, full/empty); FSM and write decode in top.

## Test plan
- Reset then idle: all outputs at reset values; `upd_ready=1`.
- Single report pc=0x1c000010, tpc=0x1c000100, btype=01, taken, add_fail at N -> cycle N+1 `btb_we=1, btb_widx=0x02, btb_wtarget=0x1c000100, btb_wvalid=1`, `dir_we=0`.
- Fill: 4 non-coalescing reports with drain blocked by SWEEP entry... instead send 5 back-to-back during SWEEP -> `upd_ready=0`, none enqueued; after sweep, 4 distinct reports in 4 cycles drain in order, one per cycle.
- Coalesce: two reports same index 0x05, tpc 0xA then 0xB in consecutive cycles while queue holds an older entry -> only one write to 0x05 with target 0xB.
- `btype=10`, not taken, dir_fail -> `dir_we=1, dir_taken=0`, `btb_we=0`; `btype=00` report at idx 0x07 -> `btb_we=1, btb_wvalid=0`.
- `inv_req` with 3 queued entries -> queue discarded, 256 clears idx 0..255, `inv_busy` 256 cycles; second `inv_req` at clear 100 -> restart at 0, total 357 busy cycles.

Source files
------------

// File: rtl/btb_update_ctrl_pkg.sv
// btb_update_ctrl_pkg: shared encodings and queue-entry layout for the BTB update scheduler
package btb_update_ctrl_pkg;
    localparam int IDX_W_MAX = 16;

    typedef enum logic [1:0] {
        BT_NONE     = 2'b00,
        BT_UNCOND   = 2'b01,
        BT_PCREL    = 2'b10,
        BT_INDIRECT = 2'b11
    } btype_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRAIN = 2'b01,
        ST_SWEEP = 2'b10
    } state_t;

    typedef struct packed {
        logic [IDX_W_MAX-1:0] idx;
        logic [31:0]          tpc;
        logic                 taken;
        btype_t               btype;
        logic                 dir_fail;
        logic                 add_fail;
    } upd_entry_t;
endpackage

// File: rtl/btb_update_ctrl_if.sv
// btb_update_ctrl_if: resolution-report handshake, invalidate request and BTB/direction write port
interface btb_update_ctrl_if #(
    parameter int INDEX_WIDTH = 8
);
    logic                   upd_valid;
    logic                   upd_ready;
    logic [31:0]            upd_pc;
    logic [31:0]            upd_tpc;
    logic                   upd_taken;
    logic [1:0]             upd_btype;
    logic                   upd_dir_fail;
    logic                   upd_add_fail;
    logic                   inv_req;
    logic                   inv_busy;
    logic                   btb_we;
    logic [INDEX_WIDTH-1:0] btb_widx;
    logic [31:0]            btb_wtarget;
    logic                   btb_wvalid;
    logic                   dir_we;
    logic                   dir_taken;

    modport master (
        output upd_valid, upd_pc, upd_tpc, upd_taken, upd_btype, upd_dir_fail, upd_add_fail, inv_req,
        input  upd_ready, inv_busy, btb_we, btb_widx, btb_wtarget, btb_wvalid, dir_we, dir_taken
    );

    modport slave (
        input  upd_valid, upd_pc, upd_tpc, upd_taken, upd_btype, upd_dir_fail, upd_add_fail, inv_req,
        output upd_ready, inv_busy, btb_we, btb_widx, btb_wtarget, btb_wvalid, dir_we, dir_taken
    );
endinterface

// File: rtl/btb_update_ctrl_fifo.sv
// btb_upd_fifo: small circular update queue with tail overwrite and flush
module btb_upd_fifo
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   ovr,
    input  upd_entry_t             din,
    output upd_entry_t             head,
    output upd_entry_t             tail,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    upd_entry_t        mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     tl_ptr;

    // head, newest entry and occupancy flags
    always_comb begin
        tl_ptr = wr_ptr - AW'(1);
        head   = mem[rd_ptr];
        tail   = mem[tl_ptr];
        full   = count == (AW+1)'(DEPTH);
        empty  = count == '0;
    end

    // entry storage: push writes a new slot, overwrite replaces the newest slot
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
        else if (ovr)
            mem[tl_ptr] <= din;
    end

    // pointers and occupancy; flush drops every entry at once
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: schedules branch-resolution writes and full-table invalidate sweeps onto the BTB write port
module btb_update_ctrl
    import btb_update_ctrl_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int INDEX_WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    btb_update_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t               state;
    state_t               state_nx;
    logic [INDEX_WIDTH:0] cnt;
    logic [INDEX_WIDTH:0] cnt_nx;
    upd_entry_t           din;
    upd_entry_t           head;
    upd_entry_t           tail;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nx;
    logic                 full;
    logic                 empty;
    logic                 sweep;
    logic                 ready;
    logic                 enq;
    logic                 pop;
    logic                 ovr;
    logic                 push;
    logic                 sweep_end;
    logic                 h_clear;
    logic                 h_ins;
    logic                 unused_bits;

    assign unused_bits = ^{bus.upd_pc, head.idx};

    btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.inv_req),
        .push  (push),
        .pop   (pop),
        .ovr   (ovr),
        .din   (din),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // accept, filter and coalesce incoming reports; a same-cycle invalidate drops the report
    always_comb begin
        sweep         = state == ST_SWEEP;
        ready         = !full && !sweep;
        bus.upd_ready = ready;
        bus.inv_busy  = sweep;
        din           = '{idx: IDX_W_MAX'(bus.upd_pc[INDEX_WIDTH+2:3]), tpc: bus.upd_tpc,
                          taken: bus.upd_taken, btype: btype_t'(bus.upd_btype),
                          dir_fail: bus.upd_dir_fail, add_fail: bus.upd_add_fail};
        enq           = bus.upd_valid && ready && !bus.inv_req &&
                        (bus.upd_add_fail || bus.upd_dir_fail || bus.upd_btype == BT_NONE);
        pop           = state == ST_DRAIN && !bus.inv_req;
        ovr           = enq && !empty && tail.idx == din.idx && !(pop && count == CW'(1));
        push          = enq && !ovr;
        count_nx      = bus.inv_req ? '0 : count + CW'(push) - CW'(pop);
    end

    // next state and sweep counter; invalidate always (re)starts the sweep from index 0
    always_comb begin
        sweep_end = &cnt[INDEX_WIDTH-1:0];
        state_nx  = bus.inv_req ? ST_SWEEP :
                    sweep       ? (sweep_end ? ST_IDLE : ST_SWEEP) :
                    count_nx != '0 ? ST_DRAIN : ST_IDLE;
        cnt_nx    = bus.inv_req ? '0 : sweep ? cnt + (INDEX_WIDTH+1)'(1) : cnt;
    end

    // state and sweep counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // write-port decode: sweep clears, otherwise the queue head clears, inserts and/or trains
    always_comb begin
        h_clear         = head.btype == BT_NONE;
        h_ins           = head.taken && head.add_fail && !h_clear;
        bus.btb_we      = sweep || (pop && (h_clear || h_ins));
        bus.btb_wvalid  = pop && h_ins;
        bus.btb_widx    = sweep ? cnt[INDEX_WIDTH-1:0] : pop ? head.idx[INDEX_WIDTH-1:0] : '0;
        bus.btb_wtarget = pop && h_ins ? head.tpc : '0;
        bus.dir_we      = pop && head.btype == BT_PCREL;
        bus.dir_taken   = pop && head.btype == BT_PCREL && head.taken;
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb_btb_update_ctrl: directed and randomized checks of btb_update_ctrl against a queue-level model
module tb_btb_update_ctrl;
    localparam int DEPTH = 4;
    localparam int IW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   chk_on = 1'b0;

    btb_update_ctrl_if #(.INDEX_WIDTH(IW)) bus ();

    btb_update_ctrl #(.DEPTH(DEPTH), .INDEX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [31:0] tpc;
        bit          taken;
        bit [1:0]    bt;
        bit          df;
        bit          af;
    } rep_t;

    rep_t q[$];
    rep_t h;
    rep_t r;
    int   sweep_pos = -1;
    bit   e_ready, e_busy, e_we, e_wvalid, e_dwe, e_dtk;
    int   e_widx;
    logic [31:0] e_tgt;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endtask

    // model: queue of pending reports plus sweep position; checked mid-cycle, then advanced
    always @(negedge clk) begin
        if (chk_on) begin
            e_ready  = sweep_pos < 0 && q.size() < DEPTH;
            e_busy   = sweep_pos >= 0;
            e_we     = 0;
            e_wvalid = 0;
            e_widx   = 0;
            e_tgt    = 0;
            e_dwe    = 0;
            e_dtk    = 0;
            if (e_busy) begin
                e_we   = 1;
                e_widx = sweep_pos;
            end else if (q.size() > 0 && !bus.inv_req) begin
                h        = q[0];
                e_we     = h.bt == 0 || (h.taken && h.af);
                e_wvalid = h.bt != 0 && h.taken && h.af;
                e_widx   = h.idx;
                e_tgt    = e_wvalid ? h.tpc : 32'h0;
                e_dwe    = h.bt == 2;
                e_dtk    = h.taken;
            end
            chk("upd_ready", 32'(bus.upd_ready), 32'(e_ready));
            chk("inv_busy", 32'(bus.inv_busy), 32'(e_busy));
            chk("btb_we", 32'(bus.btb_we), 32'(e_we));
            chk("dir_we", 32'(bus.dir_we), 32'(e_dwe));
            if (e_we) begin
                chk("btb_widx", 32'(bus.btb_widx), 32'(e_widx));
                chk("btb_wvalid", 32'(bus.btb_wvalid), 32'(e_wvalid));
                if (e_busy || e_wvalid) chk("btb_wtarget", bus.btb_wtarget, e_tgt);
            end
            if (e_dwe) chk("dir_taken", 32'(bus.dir_taken), 32'(e_dtk));
            if (!e_busy && q.size() == 0) begin
                chk("idle_widx", 32'(bus.btb_widx), 32'h0);
                chk("idle_wtarget", bus.btb_wtarget, 32'h0);
                chk("idle_wvalid", 32'(bus.btb_wvalid), 32'h0);
                chk("idle_dir_taken", 32'(bus.dir_taken), 32'h0);
            end
            if (rst) begin
                q.delete();
                sweep_pos = -1;
            end else if (bus.inv_req) begin
                q.delete();
                sweep_pos = 0;
            end else if (e_busy) begin
                sweep_pos = sweep_pos == (1 << IW) - 1 ? -1 : sweep_pos + 1;
            end else begin
                if (q.size() > 0) void'(q.pop_front());
                if (bus.upd_valid && e_ready && (bus.upd_add_fail || bus.upd_dir_fail || bus.upd_btype == 2'b00)) begin
                    r.idx   = int'(bus.upd_pc[IW+2:3]);
                    r.tpc   = bus.upd_tpc;
                    r.taken = bus.upd_taken;
                    r.bt    = bus.upd_btype;
                    r.df    = bus.upd_dir_fail;
                    r.af    = bus.upd_add_fail;
                    if (q.size() > 0 && q[q.size()-1].idx == r.idx) q[q.size()-1] = r;
                    else q.push_back(r);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] tpc, input bit tk,
                        input bit [1:0] bt, input bit df, input bit af);
        bus.upd_valid    = 1'b1;
        bus.upd_pc       = pc;
        bus.upd_tpc      = tpc;
        bus.upd_taken    = tk;
        bus.upd_btype    = bt;
        bus.upd_dir_fail = df;
        bus.upd_add_fail = af;
    endtask

    task automatic quiet();
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = 32'h0;
        bus.upd_tpc      = 32'h0;
        bus.upd_taken    = 1'b0;
        bus.upd_btype    = 2'b00;
        bus.upd_dir_fail = 1'b0;
        bus.upd_add_fail = 1'b0;
        bus.inv_req      = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.inv_busy && n < 400) begin
            step();
            #3;
            n++;
        end
        chk("wait_idle", 32'(bus.inv_busy), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        quiet();
        rst         = 1'b1;
        bus.inv_req = 1'b1;
        step();
        chk_on = 1'b1;
        #3;
        chk("rst_ready", 32'(bus.upd_ready), 32'h1);
        chk("rst_busy", 32'(bus.inv_busy), 32'h0);
        chk("rst_btb_we", 32'(bus.btb_we), 32'h0);
        chk("rst_dir_we", 32'(bus.dir_we), 32'h0);
        chk("rst_widx", 32'(bus.btb_widx), 32'h0);
        chk("rst_wtarget", bus.btb_wtarget, 32'h0);
        chk("rst_wvalid", 32'(bus.btb_wvalid), 32'h0);
        chk("rst_dir_taken", 32'(bus.dir_taken), 32'h0);
        step();
        rst         = 1'b0;
        bus.inv_req = 1'b0;
        #3;
        chk("rst_beats_inv", 32'(bus.inv_busy), 32'h0);

        send(32'h1c000010, 32'h1c000100, 1'b1, 2'b01, 1'b0, 1'b1);
        step();
        quiet();
        #3;
        chk("single_we", 32'(bus.btb_we), 32'h1);
        chk("single_widx", 32'(bus.btb_widx), 32'h02);
        chk("single_wtarget", bus.btb_wtarget, 32'h1c000100);
        chk("single_wvalid", 32'(bus.btb_wvalid), 32'h1);
        chk("single_dir_we", 32'(bus.dir_we), 32'h0);

        step();
        send(32'h1c000048, 32'h0, 1'b0, 2'b10, 1'b1, 1'b0);
        step();
        quiet();
        #3;
        chk("pcrel_dir_we", 32'(bus.dir_we), 32'h1);
        chk("pcrel_dir_taken", 32'(bus.dir_taken), 32'h0);
        chk("pcrel_btb_we", 32'(bus.btb_we), 32'h0);

        step();
        send(32'h1c000038, 32'h1234, 1'b0, 2'b00, 1'b0, 1'b0);
        step();
        quiet();
        #3;
        chk("clear_we", 32'(bus.btb_we), 32'h1);
        chk("clear_wvalid", 32'(bus.btb_wvalid), 32'h0);
        chk("clear_widx", 32'(bus.btb_widx), 32'h07);

        step();
        send(32'h1c000060, 32'h5555, 1'b1, 2'b01, 1'b0, 1'b0);
        step();
        quiet();
        #3;
        chk("drop_btb_we", 32'(bus.btb_we), 32'h0);
        chk("drop_dir_we", 32'(bus.dir_we), 32'h0);

        step();
        send(32'h1c000028, 32'hA, 1'b1, 2'b01, 1'b0, 1'b1);
        step();
        send(32'h1c000028, 32'hB, 1'b1, 2'b01, 1'b0, 1'b1);
        step();
        quiet();
        #3;
        chk("coal_widx", 32'(bus.btb_widx), 32'h05);
        chk("coal_wtarget", bus.btb_wtarget, 32'hB);

        step();
        bus.inv_req = 1'b1;
        step();
        bus.inv_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(32'h1c000100 + 32'(i << 3), 32'h500 + 32'(i), 1'b1, 2'b01, 1'b0, 1'b1);
            #3;
            chk("fill_ready_low", 32'(bus.upd_ready), 32'h0);
            step();
        end
        quiet();
        #3;
        wait_idle();
        chk("fill_none_enqueued", 32'(bus.btb_we), 32'h0);
        for (int i = 0; i < 4; i++) begin
            send(32'((16 + i) << 3), 32'h2000 + 32'(i), 1'b1, 2'b01, 1'b0, 1'b1);
            step();
            #3;
            chk("fill_order_idx", 32'(bus.btb_widx), 32'(16 + i));
        end
        quiet();
        step();

        send(32'h1c000198, 32'h77, 1'b1, 2'b11, 1'b0, 1'b1);
        step();
        send(32'h1c0001a0, 32'h88, 1'b1, 2'b11, 1'b0, 1'b1);
        bus.inv_req = 1'b1;
        step();
        quiet();
        #3;
        chk("sweep_first_idx", 32'(bus.btb_widx), 32'h0);
        busy = 0;
        while (bus.inv_busy && busy < 400) begin
            busy++;
            step();
            #3;
        end
        chk("sweep_len", 32'(busy), 32'd256);
        chk("sweep_end_ready", 32'(bus.upd_ready), 32'h1);
        chk("sweep_no_stale", 32'(bus.btb_we), 32'h0);

        bus.inv_req = 1'b1;
        step();
        bus.inv_req = 1'b0;
        #3;
        busy = 0;
        while (bus.inv_busy && busy < 800) begin
            if (busy == 100) begin
                chk("restart_at_idx", 32'(bus.btb_widx), 32'd100);
                bus.inv_req = 1'b1;
            end
            busy++;
            step();
            bus.inv_req = 1'b0;
            #3;
        end
        chk("restart_len", 32'(busy), 32'd357);

        for (int c = 0; c < 4000; c++) begin
            bus.upd_valid    = $urandom_range(0, 9) < 6;
            bus.upd_pc       = ($urandom() & ~32'h7f8) | (32'($urandom_range(0, 7)) << 3);
            bus.upd_tpc      = $urandom();
            bus.upd_taken    = 1'($urandom_range(0, 1));
            bus.upd_btype    = 2'($urandom_range(0, 3));
            bus.upd_dir_fail = 1'($urandom_range(0, 1));
            bus.upd_add_fail = 1'($urandom_range(0, 1));
            bus.inv_req      = $urandom_range(0, 399) == 0;
            rst              = $urandom_range(0, 999) == 0;
            step();
        end
        quiet();
        rst = 1'b0;
        step();
        #3;
        wait_idle();
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
